// File: rtl/nb_node_proc_seq.sv
// nb_node_proc_seq -- address sequencer for one LDPC decoder processing phase.
//
// A start pulse from the iteration controller launches a sweep of ROWS
// message-memory addresses. Each read is mirrored as a write-back PIPE cycles
// later, which models the processing pipeline. A one-cycle bank-wide finish
// pulse is raised once the last write-back has gone out. A variable-node
// sweep ends with finish_H and a check-node sweep ends with finish_P.
//
// Optional feature: define NB_PROC_ERR_EN to add the sticky proto_err output.
// proto_err flags start pulses that were ignored, or value/check starts that
// arrived together.
//
// Handshake: value_start and check_start are fire-and-forget pulses. They are
// accepted only when the sequencer is idle, and reset overrides them. No
// back-pressure exists. rd_en/wr_en are single-cycle strobes, and the address
// buses read 0 whenever their strobe is low.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   value_start         pulse: start variable-node phase
//   check_start         pulse: start check-node phase (wins over value_start)
//   first_iter_flag     sampled with check_start, drives llr_sel
//   rd_en, rd_addr      read strobe / address (0..ROWS-1)
//   wr_en, wr_addr      write-back strobe / address, rd delayed PIPE cycles
//   phase               0 variable-node, 1 check-node (valid while busy)
//   llr_sel             latched first_iter_flag for a check phase, else 0
//   busy                high from the cycle after accept through the finish pulse
//   finish_H, finish_P  end-of-phase pulses for the H and P banks
//   proto_err           (NB_PROC_ERR_EN only) sticky protocol-violation flag
module nb_node_proc_seq #(
  parameter int ROWS = 100,
  parameter int PIPE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       value_start,
  input  logic       check_start,
  input  logic       first_iter_flag,
  output logic       rd_en,
  output logic [6:0] rd_addr,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic       phase,
  output logic       llr_sel,
  output logic       busy,
  output logic [9:0] finish_H,
`ifdef NB_PROC_ERR_EN
  output logic       proto_err,
`endif
  output logic [4:0] finish_P
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // state is kept as a plain named signal so that checkers can bind to it.
  state_t     state;
  logic [6:0] cnt;
  logic [3:0] dcnt;
  logic       start_any;

  // Write-back delay line. Each stage holds the strobe and address of one read.
  logic       pipe_en   [PIPE];
  logic [6:0] pipe_addr [PIPE];

  assign start_any = value_start | check_start;
  assign wr_en     = pipe_en[PIPE-1];
  assign wr_addr   = pipe_addr[PIPE-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dcnt     <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      phase    <= 1'b0;
      llr_sel  <= 1'b0;
      busy     <= 1'b0;
      finish_H <= '0;
      finish_P <= '0;
    end else begin
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      finish_H <= '0;
      finish_P <= '0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start_any) begin
            state   <= RUN;
            // check_start has priority when both starts arrive together.
            phase   <= check_start;
            llr_sel <= check_start & first_iter_flag;
            cnt     <= '0;
          end
        end
        RUN: begin
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_addr <= cnt;
          // The counter parks at ROWS-1 and never wraps.
          if (cnt == 7'(ROWS - 1)) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        DRAIN: begin
          // Wait PIPE cycles so that the last read reaches the write-back port.
          busy <= 1'b1;
          if (dcnt == 4'(PIPE - 1)) state <= DONE;
          else                      dcnt  <= dcnt + 4'd1;
        end
        DONE: begin
          // The finish pulse goes out in the cycle after the last write-back.
          // The next edge returns to IDLE, so a start can be taken at once.
          busy     <= 1'b1;
          finish_H <= {10{~phase}};
          finish_P <= {5{phase}};
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) begin
        pipe_en[i]   <= 1'b0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_en[0]   <= rd_en;
      pipe_addr[0] <= rd_addr;
      for (int i = 1; i < PIPE; i++) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

`ifdef NB_PROC_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (start_any && ((state != IDLE) || (value_start && check_start))) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nb_node_proc_seq.sv
// Testbench for nb_node_proc_seq.
// The main instance uses the default configuration. A second instance uses
// ROWS=2 and PIPE=1 to exercise the minimum sweep and back-to-back starts.
module tb_nb_node_proc_seq;
  localparam int ROWS = 100;
  localparam int PIPE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, value_start, check_start, first_iter_flag;
  logic       rd_en, wr_en, phase, llr_sel, busy;
  logic [6:0] rd_addr, wr_addr;
  logic [9:0] finish_H;
  logic [4:0] finish_P;
`ifdef NB_PROC_ERR_EN
  logic       proto_err, proto_err2;
`endif

  logic       v2 = 1'b0, c2 = 1'b0, f2 = 1'b0;
  logic       rd_en2, wr_en2, phase2, llr_sel2, busy2;
  logic [6:0] rd_addr2, wr_addr2;
  logic [9:0] finish_H2;
  logic [4:0] finish_P2;

  nb_node_proc_seq #(.ROWS(ROWS), .PIPE(PIPE)) dut (
    .clk(clk), .reset(reset), .value_start(value_start), .check_start(check_start),
    .first_iter_flag(first_iter_flag), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .phase(phase), .llr_sel(llr_sel),
    .busy(busy), .finish_H(finish_H),
`ifdef NB_PROC_ERR_EN
    .proto_err(proto_err),
`endif
    .finish_P(finish_P)
  );

  nb_node_proc_seq #(.ROWS(2), .PIPE(1)) dut2 (
    .clk(clk), .reset(reset), .value_start(v2), .check_start(c2),
    .first_iter_flag(f2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .phase(phase2), .llr_sel(llr_sel2),
    .busy(busy2), .finish_H(finish_H2),
`ifdef NB_PROC_ERR_EN
    .proto_err(proto_err2),
`endif
    .finish_P(finish_P2)
  );

  // Number of rising edges seen so far. The monitor reads it at the falling edge.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- scoreboard state ----------------
  // Event packing: {edge stamp[40:9], addr[8:2], phase[1], llr_sel[0]}
  logic [40:0] rd_q[$];
  logic [40:0] wr_q[$];
  logic [40:0] fin_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_e  = 0;   // edge of the most recently accepted start
  int   end_e  = -1;  // last busy edge of that sweep (finish edge)
  logic err_exp = 1'b0;
  bit   mon_on  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask

  // ---------------- driver + reference model ----------------
  // The model works in whole sweeps: an accepted start at edge e schedules
  // every read, write-back and finish event with its absolute edge number.
  task automatic step(input logic vs, input logic cs, input logic fl, input logic rs);
    int e;
    e = edge_n + 1;
    value_start = vs; check_start = cs; first_iter_flag = fl; reset = rs;
    if (rs) begin
      rd_q.delete(); wr_q.delete(); fin_q.delete();
      end_e   = e - 1;
      err_exp = 1'b0;
    end else if (vs || cs) begin
      if (e <= end_e || (vs && cs)) err_exp = 1'b1;
      if (e > end_e) begin
        for (int i = 0; i < ROWS; i++) begin
          rd_q.push_back({32'(e + 1 + i), 7'(i), cs, cs & fl});
          wr_q.push_back({32'(e + 1 + PIPE + i), 7'(i), 2'b00});
        end
        fin_q.push_back({32'(e + ROWS + PIPE + 1), 7'd0, cs, 1'b0});
        acc_e = e;
        end_e = e + ROWS + PIPE + 1;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [40:0] x;
    if (mon_on) begin
      while (rd_q.size() > 0 && int'(rd_q[0][40:9]) < edge_n) begin
        x = rd_q.pop_front();
        chk("rd_missed", 64'(edge_n), 64'(x[40:9]));
      end
      while (wr_q.size() > 0 && int'(wr_q[0][40:9]) < edge_n) begin
        x = wr_q.pop_front();
        chk("wr_missed", 64'(edge_n), 64'(x[40:9]));
      end
      while (fin_q.size() > 0 && int'(fin_q[0][40:9]) < edge_n) begin
        x = fin_q.pop_front();
        chk("finish_missed", 64'(edge_n), 64'(x[40:9]));
      end

      if (rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 64'(rd_en), 64'(0));
        else begin
          x = rd_q.pop_front();
          chk("rd_time", 64'(edge_n), 64'(x[40:9]));
          chk("rd_addr", 64'(rd_addr), 64'(x[8:2]));
          chk("phase", 64'(phase), 64'(x[1]));
          chk("llr_sel", 64'(llr_sel), 64'(x[0]));
        end
      end else chk("rd_addr_idle", 64'(rd_addr), 64'(0));

      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 64'(wr_en), 64'(0));
        else begin
          x = wr_q.pop_front();
          chk("wr_time", 64'(edge_n), 64'(x[40:9]));
          chk("wr_addr", 64'(wr_addr), 64'(x[8:2]));
        end
      end else chk("wr_addr_idle", 64'(wr_addr), 64'(0));

      if (finish_H != 10'd0 || finish_P != 5'd0) begin
        if (fin_q.size() == 0) chk("finish_unexpected", 64'({finish_H, finish_P}), 64'(0));
        else begin
          x = fin_q.pop_front();
          chk("finish_time", 64'(edge_n), 64'(x[40:9]));
          chk("finish_bits", 64'({finish_H, finish_P}), x[1] ? 64'h001F : 64'h7FE0);
        end
      end

      chk("busy", 64'(busy), 64'(edge_n > acc_e && edge_n <= end_e));
`ifdef NB_PROC_ERR_EN
      chk("proto_err", 64'(proto_err), 64'(err_exp));
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, e2;
    logic exp_rd, exp_wr, exp_busy;
    logic [6:0] exp_ra, exp_wa;
    logic [9:0] exp_fh;
    logic [4:0] exp_fp;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);  // starts together with reset are dropped
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_outputs",
        64'({rd_en, rd_addr, wr_en, wr_addr, phase, llr_sel, busy, finish_H, finish_P}), 64'(0));
    mon_on = 1'b1;
    idle(3);

    // Variable-node phase.
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(110);
    // Check-node phase, first iteration, then a later iteration.
    step(1'b0, 1'b1, 1'b1, 1'b0); idle(110);
    step(1'b0, 1'b1, 1'b0, 1'b0); idle(110);
    // A value_start 50 edges into a check sweep is ignored.
    step(1'b0, 1'b1, 1'b1, 1'b0); idle(49);
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(60);
    // Simultaneous starts: the check phase runs.
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(110);
    // Reset 60 edges into a sweep, then a fresh variable phase.
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(59);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(110);

    // Random traffic: dense starts, occasional resets.
    repeat (4000) begin
      step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 499) == 0));
    end

    n = 0;
    while (n < 300 && (rd_q.size() + wr_q.size() + fin_q.size()) > 0) begin
      idle(1);
      n++;
    end
    chk("scoreboard_drained", 64'(rd_q.size() + wr_q.size() + fin_q.size()), 64'(0));
    idle(5);

    // Small configuration: ROWS=2, PIPE=1, with a check start taken right after DONE.
    v2 = 1'b1;
    e2 = edge_n + 1;
    idle(1);
    v2 = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      idle(1);
      exp_rd   = (j == 1 || j == 2 || j == 6 || j == 7);
      exp_ra   = (j == 2 || j == 7) ? 7'd1 : 7'd0;
      exp_wr   = (j == 2 || j == 3 || j == 7 || j == 8);
      exp_wa   = (j == 3 || j == 8) ? 7'd1 : 7'd0;
      exp_fh   = (j == 4) ? 10'h3FF : 10'h000;
      exp_fp   = (j == 9) ? 5'h1F : 5'h00;
      exp_busy = (j >= 1 && j <= 4) || (j >= 6 && j <= 9);
      chk($sformatf("small_cfg_edge_%0d", edge_n - e2),
          64'({rd_en2, rd_addr2, wr_en2, wr_addr2, finish_H2, finish_P2, busy2}),
          64'({exp_rd, exp_ra, exp_wr, exp_wa, exp_fh, exp_fp, exp_busy}));
      if (j >= 6) chk("small_cfg_phase", 64'(phase2), 64'(1));
      if (j == 4) c2 = 1'b1;
      if (j == 5) c2 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
